// File: rtl/lfsr_random_gen_pkg.sv
// Shared constants, FSM encoding and the LFSR step function for the random generator.
package lfsr_random_gen_pkg;

    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_WARM   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SEARCH = 2'd2
    } gen_state_e;

    // One Galois step of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr_random_gen_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous line followed by a one-cycle rising-edge pulse.
module sync_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/lfsr_random_gen.sv
// Random source for the regfile r29 port: free-running Galois LFSR with warm-up, reseed and
// button-timing entropy, plus a request port returning a non-repeating mole index.
module lfsr_random_gen
    import lfsr_random_gen_pkg::*;
#(
    parameter int                LFSR_W    = 16,
    parameter int                OUT_W     = 8,
    parameter int                NUM_MOLES = 9,
    parameter int                WARMUP    = 32,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              reseed,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic              entropy_in,
    input  logic              hold,
    output logic [OUT_W-1:0]  random_data,
    output logic              random_valid,
    input  logic              mole_req,
    output logic              mole_busy,
    output logic [3:0]        mole_index,
    output logic              mole_valid,
    output gen_state_e        dbg_state_o
);

    localparam int                 WARM_CW   = (WARMUP < 2) ? 1 : $clog2(WARMUP);
    localparam logic [WARM_CW-1:0] WARM_LAST = WARM_CW'(WARMUP - 1);
    localparam logic [4:0]         MOLES_L   = 5'(NUM_MOLES);

    gen_state_e         state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]  stamp_q;
    logic [WARM_CW-1:0] warm_q, warm_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic [3:0]         idx_q, idx_d;
    logic [3:0]         prev_q, prev_d;
    logic               mvalid_q, mvalid_d;
    logic               pending_q, pending_d;
    logic               stir;
    logic [3:0]         cand;
    logic               cand_ok;

    sync_edge_detect u_entropy_sync (
        .clk_i   (clock),
        .rst_ni  (ctrl_reset),
        .async_i (entropy_in),
        .rise_o  (stir)
    );

    // Reseed beats stirring; a stir that lands on zero falls back to SEED so the LFSR never locks.
    always_comb begin
        lfsr_d = lfsr_step(lfsr_q);
        if (reseed) begin
            lfsr_d = (seed_value == '0) ? SEED : seed_value;
        end else if (stir) begin
            lfsr_d = lfsr_step(lfsr_q) ^ stamp_q;
            if (lfsr_d == '0) begin
                lfsr_d = SEED;
            end
        end
    end

    assign cand    = lfsr_q[3:0];
    assign cand_ok = ({1'b0, cand} < MOLES_L) && (cand != prev_q);

    // Handshake: a 1-cycle mole_req is taken only while mole_busy is low; mole_busy stays high
    // until the accept edge, after which mole_valid pulses for one cycle with mole_index updated.
    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        data_d    = data_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        prev_d    = prev_q;
        mvalid_d  = 1'b0;
        pending_d = pending_q;
        if (reseed) begin
            state_d   = ST_WARM;
            warm_d    = '0;
            valid_d   = 1'b0;
            pending_d = mole_req;
        end else begin
            case (state_q)
                ST_WARM: begin
                    if (mole_req) begin
                        pending_d = 1'b1;
                    end
                    if (warm_q == WARM_LAST) begin
                        valid_d   = 1'b1;
                        data_d    = lfsr_d[OUT_W-1:0];
                        state_d   = (pending_q || mole_req) ? ST_SEARCH : ST_RUN;
                        pending_d = 1'b0;
                    end else begin
                        warm_d = warm_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
                        data_d = lfsr_d[OUT_W-1:0];
                    end
                    if (mole_req) begin
                        state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (!hold) begin
                        data_d = lfsr_d[OUT_W-1:0];
                    end
                    if (cand_ok) begin
                        idx_d    = cand;
                        prev_d   = cand;
                        mvalid_d = 1'b1;
                        state_d  = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_WARM;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q   <= ST_WARM;
            lfsr_q    <= SEED;
            stamp_q   <= '0;
            warm_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            idx_q     <= 4'h0;
            prev_q    <= 4'hF;
            mvalid_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            stamp_q   <= stamp_q + 1'b1;
            warm_q    <= warm_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            prev_q    <= prev_d;
            mvalid_q  <= mvalid_d;
            pending_q <= pending_d;
        end
    end

    assign random_data  = data_q;
    assign random_valid = valid_q;
    assign mole_index   = idx_q;
    assign mole_valid   = mvalid_q;
    assign mole_busy    = (state_q == ST_SEARCH) || pending_q;
    assign dbg_state_o  = state_q;

endmodule
